// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmitter/receiver pair so one register bank
// can configure both directions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    typedef enum logic [1:0] {
        STOP_1   = 2'b00,
        STOP_0P5 = 2'b01,
        STOP_2   = 2'b10,
        STOP_1P5 = 2'b11
    } stop_len_e;

    localparam int unsigned BAUD_B_MSB = 15;
    localparam int unsigned BAUD_B_LSB = 4;
    localparam int unsigned BAUD_F_MSB = 3;
    localparam int unsigned BAUD_F_LSB = 0;

    // IrDA low pulse length, in sub-periods
    localparam logic [4:0] IRDA_PULSE_SUBS = 5'd3;

    typedef struct packed {
        logic [11:0] b;
        logic [3:0]  f;
        logic        word_len;
        logic        parity_en;
        logic        parity_type;
        stop_len_e   stop_len;
        logic        irda;
    } tx_cfg_t;

    function automatic logic [11:0] baud_b(input logic [15:0] br);
        return br[BAUD_B_MSB:BAUD_B_LSB];
    endfunction

    function automatic logic [3:0] baud_f(input logic [15:0] br);
        return br[BAUD_F_MSB:BAUD_F_LSB];
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Sub-bit timing: 16 sub-periods of B clocks plus an optional 17th of F clocks.
// Outputs are registered; the *_nxt outputs give the values for the coming cycle.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] b_i,
    input  logic [3:0]  f_i,
    input  logic        run_i,
    input  logic        clr_i,
    output logic        bit_end_o,
    output logic [4:0]  sub_cnt_nxt_o,
    output logic        sub_tick_nxt_o,
    output logic        bit_end_nxt_o
);

    logic [11:0] clk_cnt_q, clk_cnt_d;
    logic [4:0]  sub_cnt_q, sub_cnt_d;
    logic        tick_q, tick_d;
    logic        bend_q, bend_d;
    logic [11:0] b_eff;
    logic [11:0] sub_len;

    // b_i/f_i and run_i describe the cycle being entered, so the tick flags
    // are decoded one cycle early and land in registers aligned with the counters.
    always_comb begin
        b_eff     = (b_i == '0) ? 12'd1 : b_i;
        clk_cnt_d = clk_cnt_q;
        sub_cnt_d = sub_cnt_q;
        if (!run_i || clr_i) begin
            clk_cnt_d = '0;
            sub_cnt_d = '0;
        end else if (tick_q) begin
            clk_cnt_d = '0;
            sub_cnt_d = bend_q ? 5'd0 : sub_cnt_q + 5'd1;
        end else begin
            clk_cnt_d = clk_cnt_q + 12'd1;
        end
        sub_len = (sub_cnt_d == 5'd16) ? {8'd0, f_i} : b_eff;
        tick_d  = run_i && (clk_cnt_d == sub_len - 12'd1);
        bend_d  = tick_d && ((sub_cnt_d == 5'd16) || ((sub_cnt_d == 5'd15) && (f_i == '0)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_cnt_q <= '0;
            sub_cnt_q <= '0;
            tick_q    <= 1'b0;
            bend_q    <= 1'b0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            sub_cnt_q <= sub_cnt_d;
            tick_q    <= tick_d;
            bend_q    <= bend_d;
        end
    end

    assign bit_end_o      = bend_q;
    assign sub_cnt_nxt_o  = sub_cnt_d;
    assign sub_tick_nxt_o = tick_d;
    assign bit_end_nxt_o  = bend_d;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, LSB-first data, optional parity/9th bit, stop period,
// with optional 3/16 IrDA pulse encoding.
module uart_transmitter
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic [15:0] baud_rate,
    input  logic        word_len,
    input  logic        parity_en,
    input  logic        parity_type,
    input  logic [1:0]  stop_len,
    input  logic        irda_mode,
    input  logic        tx_vld,
    output logic        tx_rdy,
    input  logic [7:0]  tx_byte,
    input  logic        tx_bit8,
    output logic        tx_dout,
    output logic        tx_done_p,
    output logic [7:0]  tx_state
);

    uart_state_e state_q, state_d;
    tx_cfg_t     cfg_q, cfg_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        bit8_q, bit8_d;
    logic        acc_q, acc_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        dout_q, dout_d;
    logic        done_q, done_d;

    logic        accept;
    logic        gen_run;
    logic        bit_end;
    logic [4:0]  sub_nxt;
    logic        tick_nxt;
    logic        bend_nxt;
    logic [2:0]  last_idx;
    logic        par_bit;
    logic        lvl_d;
    logic        stop_last_nxt;

    // done_q marks the final stop cycle, so it doubles as the "last cycle" decode
    assign tx_rdy  = tx_en & ((state_q == ST_IDLE) | done_q);
    assign accept  = tx_vld & tx_rdy;
    assign gen_run = (state_d != ST_IDLE);

    uart_baud_gen u_baud (
        .clk_i          (clk),
        .rst_i          (rst),
        .b_i            (cfg_d.b),
        .f_i            (cfg_d.f),
        .run_i          (gen_run),
        .clr_i          (accept),
        .bit_end_o      (bit_end),
        .sub_cnt_nxt_o  (sub_nxt),
        .sub_tick_nxt_o (tick_nxt),
        .bit_end_nxt_o  (bend_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        shreg_d   = shreg_q;
        bit8_d    = bit8_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        last_idx  = (!cfg_q.word_len && cfg_q.parity_en) ? 3'd6 : 3'd7;

        if (!tx_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_START: begin
                    if (bit_end) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        acc_d   = acc_q ^ shreg_q[0];
                        if (bit_cnt_q == last_idx) begin
                            bit_cnt_d = '0;
                            state_d   = (cfg_q.parity_en || cfg_q.word_len) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_d   = ST_STOP;
                        bit_cnt_d = '0;
                    end
                end
                ST_STOP: begin
                    if (done_q) begin
                        state_d = ST_IDLE;
                    end else if (bit_end) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (accept) begin
                state_d           = ST_START;
                cfg_d.b           = baud_b(baud_rate);
                cfg_d.f           = baud_f(baud_rate);
                cfg_d.word_len    = word_len;
                cfg_d.parity_en   = parity_en;
                cfg_d.parity_type = parity_type;
                cfg_d.stop_len    = stop_len_e'(stop_len);
                cfg_d.irda        = irda_mode;
                shreg_d           = tx_byte;
                bit8_d            = tx_bit8;
                acc_d             = 1'b0;
                bit_cnt_d         = '0;
            end
        end

        par_bit = cfg_d.parity_en ? (cfg_d.parity_type ^ acc_d) : bit8_d;
        case (state_d)
            ST_START:  lvl_d = 1'b0;
            ST_DATA:   lvl_d = shreg_d[0];
            ST_PARITY: lvl_d = par_bit;
            default:   lvl_d = 1'b1;
        endcase
        dout_d = lvl_d | (cfg_d.irda && (sub_nxt >= IRDA_PULSE_SUBS));

        // Outputs are registered, so the end of the stop period is decoded one cycle ahead
        case (cfg_d.stop_len)
            STOP_1:   stop_last_nxt = bend_nxt;
            STOP_0P5: stop_last_nxt = tick_nxt && (sub_nxt == 5'd7);
            STOP_2:   stop_last_nxt = bend_nxt && (bit_cnt_d == 3'd1);
            default:  stop_last_nxt = tick_nxt && (sub_nxt == 5'd7) && (bit_cnt_d == 3'd1);
        endcase
        done_d = (state_d == ST_STOP) && stop_last_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            shreg_q   <= '0;
            bit8_q    <= 1'b0;
            acc_q     <= 1'b0;
            bit_cnt_q <= '0;
            dout_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            shreg_q   <= shreg_d;
            bit8_q    <= bit8_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
        end
    end

    assign tx_dout   = dout_q;
    assign tx_done_p = done_q;
    assign tx_state  = {5'b0, state_q};

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: per-cycle expected line/state values are
// queued at each handshake and popped against the DUT every cycle.
module tb_uart_transmitter;

    typedef struct {
        logic       lvl;
        logic       last;
        logic [2:0] st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [15:0] baud_rate;
    logic        word_len;
    logic        parity_en;
    logic        parity_type;
    logic [1:0]  stop_len;
    logic        irda_mode;
    logic        tx_vld;
    logic        tx_rdy;
    logic [7:0]  tx_byte;
    logic        tx_bit8;
    logic        tx_dout;
    logic        tx_done_p;
    logic [7:0]  tx_state;

    exp_t        exp_q[$];
    int unsigned vec  = 0;
    int unsigned miss = 0;

    int unsigned cB, cF;
    logic        cwl, cpen, cpt, cirda;
    logic [1:0]  cstop;

    always #5 clk = ~clk;

    uart_transmitter dut (
        .clk         (clk),
        .rst         (rst),
        .tx_en       (tx_en),
        .baud_rate   (baud_rate),
        .word_len    (word_len),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop_len    (stop_len),
        .irda_mode   (irda_mode),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy),
        .tx_byte     (tx_byte),
        .tx_bit8     (tx_bit8),
        .tx_dout     (tx_dout),
        .tx_done_p   (tx_done_p),
        .tx_state    (tx_state)
    );

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vec++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vec++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic configure(input logic [15:0] br, input logic wl, input logic pen,
                             input logic pt, input logic [1:0] sl, input logic ir);
        cB    = 32'(br[15:4]);
        cF    = 32'(br[3:0]);
        cwl   = wl;
        cpen  = pen;
        cpt   = pt;
        cstop = sl;
        cirda = ir;
    endtask

    task automatic push_bit(input logic v, input int unsigned dur, input logic [2:0] st);
        exp_t        e;
        int unsigned bm;
        bm = (cB == 0) ? 1 : cB;
        for (int unsigned c = 0; c < dur; c++) begin
            e.lvl  = cirda ? (v | (c >= 3 * bm)) : v;
            e.last = 1'b0;
            e.st   = st;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic b8);
        int unsigned bm, t, n, sdur;
        logic        par;
        bm  = (cB == 0) ? 1 : cB;
        t   = 16 * bm + cF;
        n   = (!cwl && cpen) ? 7 : 8;
        par = cpt;
        push_bit(1'b0, t, 3'd1);
        for (int unsigned i = 0; i < n; i++) begin
            par = par ^ d[i];
            push_bit(d[i], t, 3'd2);
        end
        if (cpen || cwl) push_bit(cpen ? par : b8, t, 3'd3);
        case (cstop)
            2'b00:   sdur = t;
            2'b01:   sdur = 8 * bm;
            2'b10:   sdur = 2 * t;
            default: sdur = t + 8 * bm;
        endcase
        push_bit(1'b1, sdur, 3'd4);
        exp_q[exp_q.size() - 1].last = 1'b1;
    endtask

    // Handshake at an idle negedge; scr=1 drops tx_vld and scrambles inputs afterwards.
    task automatic send(input logic [7:0] d, input logic b8, input bit scr);
        @(negedge clk);
        baud_rate   = {cB[11:0], cF[3:0]};
        word_len    = cwl;
        parity_en   = cpen;
        parity_type = cpt;
        stop_len    = cstop;
        irda_mode   = cirda;
        tx_byte     = d;
        tx_bit8     = b8;
        tx_vld      = 1'b1;
        chk1("rdy_at_accept", tx_rdy, 1'b1);
        push_frame(d, b8);
        @(negedge clk);
        if (scr) begin
            tx_vld      = 1'b0;
            baud_rate   = 16'h0041;
            word_len    = ~cwl;
            parity_en   = ~cpen;
            parity_type = ~cpt;
            stop_len    = ~cstop;
            irda_mode   = ~cirda;
            tx_byte     = ~d;
            tx_bit8     = ~b8;
        end
    endtask

    task automatic play(input int unsigned limit, input bit chain, input logic [7:0] nd);
        exp_t        e;
        int unsigned n;
        bit          drop;
        n    = 0;
        drop = 1'b0;
        while (exp_q.size() > 0 && n < limit) begin
            e = exp_q.pop_front();
            n++;
            chk1("dout", tx_dout, e.lvl);
            chk1("done", tx_done_p, e.last);
            chk1("rdy", tx_rdy, e.last);
            chk8("state", tx_state, {5'b0, e.st});
            if (e.last && chain) begin
                chain = 1'b0;
                drop  = 1'b1;
                push_frame(nd, 1'b0);
            end
            @(negedge clk);
            if (drop) begin
                drop   = 1'b0;
                tx_vld = 1'b0;
            end
        end
    endtask

    task automatic idle_check();
        chk8("idle_state", tx_state, 8'h00);
        chk1("idle_dout", tx_dout, 1'b1);
        chk1("idle_done", tx_done_p, 1'b0);
        chk1("idle_rdy", tx_rdy, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        tx_en       = 1'b0;
        tx_vld      = 1'b0;
        baud_rate   = 16'h0010;
        word_len    = 1'b0;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        stop_len    = 2'b00;
        irda_mode   = 1'b0;
        tx_byte     = 8'h00;
        tx_bit8     = 1'b0;
        configure(16'h0010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        repeat (3) @(negedge clk);
        chk1("rst_dout", tx_dout, 1'b1);
        chk1("rst_rdy", tx_rdy, 1'b0);
        chk1("rst_done", tx_done_p, 1'b0);
        chk8("rst_state", tx_state, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk1("dis_rdy", tx_rdy, 1'b0);
        tx_en = 1'b1;

        // 8N1, T=16
        configure(16'h0010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        send(8'h55, 1'b0, 1'b1);
        play(100000, 1'b0, 8'h00);
        idle_check();

        // 7E1, B=2 F=3
        configure(16'h0023, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        send(8'h07, 1'b0, 1'b1);
        play(100000, 1'b0, 8'h00);
        idle_check();

        // 9-bit word, 1.5 stop
        configure(16'h0020, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
        send(8'h00, 1'b1, 1'b1);
        play(100000, 1'b0, 8'h00);
        idle_check();

        // IrDA
        configure(16'h0010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        send(8'hFE, 1'b0, 1'b1);
        play(100000, 1'b0, 8'h00);
        idle_check();

        // 8 data + odd parity, half stop
        configure(16'h0010, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
        send(8'hA3, 1'b0, 1'b1);
        play(100000, 1'b0, 8'h00);
        idle_check();

        // 8N2 with F=1
        configure(16'h0011, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        send(8'h3C, 1'b0, 1'b1);
        play(100000, 1'b0, 8'h00);
        idle_check();

        // back-to-back with tx_vld held high
        configure(16'h0010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        send(8'hC3, 1'b0, 1'b0);
        tx_byte = 8'h96;
        play(100000, 1'b1, 8'h96);
        idle_check();

        // abort during data bit 3
        configure(16'h0010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        send(8'h5A, 1'b0, 1'b1);
        play(69, 1'b0, 8'h00);
        tx_en = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk8("abort_state", tx_state, 8'h00);
        chk1("abort_dout", tx_dout, 1'b1);
        chk1("abort_done", tx_done_p, 1'b0);
        chk1("abort_rdy", tx_rdy, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk1("abort_no_done", tx_done_p, 1'b0);
            chk1("abort_line", tx_dout, 1'b1);
        end
        tx_en = 1'b1;

        // reset mid-frame
        send(8'h33, 1'b0, 1'b1);
        play(40, 1'b0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk8("midrst_state", tx_state, 8'h00);
        chk1("midrst_dout", tx_dout, 1'b1);
        chk1("midrst_done", tx_done_p, 1'b0);
        rst = 1'b0;

        // recovery after reset
        send(8'h81, 1'b0, 1'b1);
        play(100000, 1'b0, 8'h00);
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmitter paired with the UART receiver. It accepts a byte (or 9-bit word) through a valid/ready handshake and serialises it onto `tx_dout`: start bit, data bits LSB-first, an optional parity/9th bit, then the stop period. Its configuration fields use the same encodings as the receiver's, so one register bank can drive both directions. It also supports the 3/16 IrDA pulse encoding.

## Interface

Parameters:
- none (the frame format is fully runtime-configured)

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous reset, active-high.
- `tx_en` in 1: enables the transmitter; 0 forces IDLE and aborts any frame in progress.
- `baud_rate` in 16: bit period. `[15:4]` = B, the integer sub-bit length in clocks; `[3:0]` = F, the extra clocks per bit.
- `word_len` in 1: 0 = 8-bit word, 1 = 9-bit word.
- `parity_en` in 1: enables the parity bit.
- `parity_type` in 1: 0 = even, 1 = odd.
- `stop_len` in 2: 00 = 1, 01 = 0.5, 10 = 2, 11 = 1.5 stop bits.
- `irda_mode` in 1: 0 = NRZ, 1 = 3/16 IrDA pulses.
- `tx_vld` in 1: a word is offered.
- `tx_rdy` out 1: a word is accepted on a cycle where `tx_vld & tx_rdy`.
- `tx_byte` in 8: data bits.
- `tx_bit8` in 1: 9th data bit (used when `word_len=1` and `parity_en=0`).
- `tx_dout` out 1: serial line.
- `tx_done_p` out 1: one-cycle pulse on the final cycle of the stop period.
- `tx_state` out 8: `[2:0]` = FSM state; `[7:3]` = 0.

## Operation

Bit timing:
- Each bit is 16 sub-periods of B clocks each.
- When F≠0, a 17th sub-period of F clocks follows. Bit period T = 16·B + F.
- B=0 is illegal; the block treats it as B=1.

FSM states: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. Any other encoding goes to IDLE.

Transitions:
- IDLE→START: on handshake. `tx_byte`, `tx_bit8` and all configuration inputs are latched at this point. Configuration changes mid-frame are ignored.
- START→DATA: after one bit period T; the line is driven 0.
- DATA: sends N bits LSB-first. N=7 if `word_len=0 & parity_en=1`, else N=8.
- DATA→PARITY: after the last data bit, if `parity_en | word_len`; otherwise DATA→STOP.
- PARITY: sends one bit for time T.
  - If `parity_en=1`, the bit is `parity_type ^ (XOR of the N data bits sent)`.
  - Otherwise the bit is the latched `tx_bit8`.
- STOP: the line is driven 1. Duration by `stop_len`:
  - 00: T
  - 01: 8·B
  - 10: 2·T
  - 11: T + 8·B
- STOP→IDLE: at the end of the stop period, with `tx_done_p` asserted on that last cycle.

IrDA (`irda_mode=1`):
- The idle line is 1.
- A 0-valued bit (including start) drives 0 only during sub-periods 0–2 and 1 for the remainder of the bit.
- A 1-valued bit drives 1 for the whole bit.

`tx_rdy` = `tx_en & (IDLE | last cycle of STOP)`. This allows back-to-back frames with no idle gap.

Abort: `tx_en=0` mid-frame gives state IDLE and `tx_dout=1` on the next cycle, with no `tx_done_p`. Any latched word is discarded.

## Timing

- Reset values: `tx_dout=1`, `tx_rdy=0`, `tx_done_p=0`, `tx_state=0`. All counters are 0.
- `tx_dout`, `tx_done_p` and the state are registered.
- `tx_rdy` is combinational from the registered state, the counters and `tx_en`.
- Latency: a handshake in cycle k puts the start bit on `tx_dout` from cycle k+1.
- Frame length from k+1 to the last stop cycle, inclusive: (1 + N + P)·T + stop duration, where P ∈ {0,1} is 1 when the PARITY state is used.
- Back-to-back: a handshake in the `tx_done_p` cycle makes the next start bit begin the following cycle.
- `rst` has priority over `tx_en`; `tx_en=0` has priority over a simultaneous `tx_vld`.

## Structure

- Shared `uart_pkg`:
  - state encodings (IDLE…STOP)
  - `stop_len` codes
  - `baud_rate` field slices
  - the IrDA pulse width constant (3)
- Sub-module `uart_baud_gen`:
  - inputs: B, F, `run`, `clr`
  - outputs: `sub_cnt[4:0]` and `sub_tick` (end of a sub-period)
  - `bit_end` = the tick at sub 15 when F=0, or the tick at sub 16 when F≠0.
- Top level: FSM, shift register, parity accumulator, and `bit_cnt[2:0]` (reused to count the two halves/bits of STOP).

## Test plan

1. `baud_rate=0x0010` (T=16), 8N1, send 0x55 → `tx_dout`=0,1,0,1,0,1,0,1,0,1, each 16 clocks. Start begins at k+1; `tx_done_p` is 160 clocks after accept.
2. `baud_rate=0x0023` (B=2, F=3, T=35), 7E1 (`parity_en=1`, `word_len=0`), send 0x07 → 7 data bits 1,1,1,0,0,0,0, then parity 1, then stop 35 clocks. Total 35·10=350.
3. 9-bit mode (`word_len=1`, `parity_en=0`), `tx_byte=0x00`, `tx_bit8=1` → 8 zeros then a 1 in the PARITY slot. `stop_len=11` gives a stop of T+8B clocks.
4. IrDA, T=16, send 0xFE → start bit = 0 for 3 clocks then 1 for 13; bit0 likewise; bits 1–7 are all 1 for the whole bit.
5. `tx_vld` held high with two words → second start bit on the cycle after `tx_done_p`; no idle gap; `tx_rdy` high only in IDLE/last stop cycle.
6. Drop `tx_en` during DATA bit 3 → next cycle IDLE, `tx_dout=1`, no `tx_done_p`. `rst` mid-frame → all reset values next cycle.
